// File: rtl/wrr_lock_arb.sv
// Weighted round-robin lock arbiter: one owner holds the grant until it releases it.
// Define WRR_TIMEOUT_EN to add a watchdog that revokes a grant held for TO_CYC cycles.
module wrr_lock_arb #(
    parameter int N      = 4,
    parameter int WW     = 3,
    parameter int TO_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          done,
    input  logic [N*WW-1:0]       weight,
    output logic [N-1:0]          gnt,
    output logic                  gnt_vld,
    output logic [$clog2(N)-1:0]  gnt_id,
    output logic                  timeout
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    gnt_nx;
    logic [IW-1:0]   id_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   sel;
    logic [WW-1:0]   run, run_nx;
    logic [WW-1:0]   w_sel, eff_w, run_cand;
    logic            release_ev;

    // (base + ofs) mod N without a divider; ofs never exceeds N-1
    function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] base, input int ofs);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(ofs);
        if (s >= (IW+1)'(N))
            s = s - (IW+1)'(N);
        return s[IW-1:0];
    endfunction

    // Rotating priority search: the lowest offset from ptr with req set wins
    always_comb begin
        sel = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[add_mod(ptr, k)])
                sel = add_mod(ptr, k);
        end
    end

    assign w_sel      = weight[sel*WW +: WW];
    assign eff_w      = (w_sel == '0) ? WW'(1) : w_sel;
    assign run_cand   = (sel == ptr) ? run + 1'b1 : WW'(1);
    assign release_ev = done[gnt_id] | ~req[gnt_id];
    assign gnt_vld    = |gnt;

`ifdef WRR_TIMEOUT_EN
    logic [15:0] wd_cnt, wd_nx;
    logic        timeout_nx;
    logic        expire;

    assign expire = (wd_cnt == 16'(TO_CYC - 1));
`else
    logic unused_to;
    assign unused_to = ^16'(TO_CYC);
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        id_nx    = gnt_id;
        ptr_nx   = ptr;
        run_nx   = run;
`ifdef WRR_TIMEOUT_EN
        wd_nx      = wd_cnt;
        timeout_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = BUSY;
                    gnt_nx   = N'(1) << sel;
                    id_nx    = sel;
                    // Stay on the winner until its consecutive-grant budget is used up
                    if (run_cand >= eff_w) begin
                        ptr_nx = add_mod(sel, 1);
                        run_nx = '0;
                    end else begin
                        ptr_nx = sel;
                        run_nx = run_cand;
                    end
`ifdef WRR_TIMEOUT_EN
                    wd_nx = '0;
`endif
                end
            end
            BUSY: begin
                if (release_ev) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                end
`ifdef WRR_TIMEOUT_EN
                else if (expire) begin
                    state_nx   = IDLE;
                    gnt_nx     = '0;
                    timeout_nx = 1'b1;
                    ptr_nx     = add_mod(gnt_id, 1);
                    run_nx     = '0;
                end else begin
                    wd_nx = wd_cnt + 16'd1;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
            run    <= '0;
`ifdef WRR_TIMEOUT_EN
            wd_cnt  <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            gnt    <= gnt_nx;
            gnt_id <= id_nx;
            ptr    <= ptr_nx;
            run    <= run_nx;
`ifdef WRR_TIMEOUT_EN
            wd_cnt  <= wd_nx;
            timeout <= timeout_nx;
`endif
        end
    end

endmodule

// File: tb/tb_wrr_lock_arb.sv
// Self-checking bench for wrr_lock_arb: directed scenarios plus random traffic against a reference model.
// Build with WRR_TIMEOUT_EN defined to exercise the watchdog.
module tb_wrr_lock_arb;

    localparam int N  = 4;
    localparam int WW = 3;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     req, done;
    logic [N*WW-1:0]  weight;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [1:0]       gnt_id;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: arbiter state as plain integers
    bit m_busy, m_to;
    int m_owner, m_ptr, m_run, m_wd, m_age;

    int seen_q[$];
    bit prev_vld;
    int to_count;

    int exp29[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    int exp30[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int exp32[8] = '{3, 0, 0, 0, 0, 0, 0, 0};
    int exp33[8] = '{1, 0, 0, 0, 0, 0, 0, 0};

    wrr_lock_arb #(.N(N), .WW(WW), .TO_CYC(TO)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .done    (done),
        .weight  (weight),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expd, $time);
        end
    endtask

    function automatic void modelReset();
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_run   = 0;
        m_wd    = 0;
        m_age   = 0;
    endfunction

    // Advance the model by one clock edge given the inputs seen at that edge
    function automatic void modelStep(input logic [N-1:0] r, input logic [N-1:0] d,
                                      input logic [N*WW-1:0] w);
        int sel, eff, rn;
        m_to = 1'b0;
        if (!m_busy) begin
            if (r != '0) begin
                sel = -1;
                for (int k = 0; k < N; k++)
                    if (sel < 0 && r[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                eff = int'(w[sel*WW +: WW]);
                if (eff == 0) eff = 1;
                rn = (sel == m_ptr) ? m_run + 1 : 1;
                if (rn >= eff) begin
                    m_ptr = (sel + 1) % N;
                    m_run = 0;
                end else begin
                    m_ptr = sel;
                    m_run = rn;
                end
                m_busy  = 1'b1;
                m_owner = sel;
                m_wd    = 0;
                m_age   = 1;
            end
        end else if (d[m_owner] || !r[m_owner]) begin
            m_busy = 1'b0;
        end else begin
`ifdef WRR_TIMEOUT_EN
            if (m_wd == TO - 1) begin
                m_busy = 1'b0;
                m_to   = 1'b1;
                m_ptr  = (m_owner + 1) % N;
                m_run  = 0;
            end else begin
                m_wd++;
                m_age++;
            end
`else
            m_age++;
`endif
        end
    endfunction

    task automatic checkCycle();
        checkOutput("gnt", gnt, m_busy ? (1 << m_owner) : 0);
        checkOutput("gnt_vld", gnt_vld, m_busy);
        if (m_busy) checkOutput("gnt_id", gnt_id, m_owner);
        checkOutput("timeout", timeout, m_to);
        checkOutput("onehot0", $onehot0(gnt), 1);
        checkOutput("vld_is_or", gnt_vld, |gnt);
        if (gnt_vld) checkOutput("gnt_at_id", gnt[gnt_id], 1);
        if (gnt_vld === 1'b1 && !prev_vld) seen_q.push_back(int'(gnt_id));
        prev_vld = (gnt_vld === 1'b1);
        if (timeout === 1'b1) to_count++;
    endtask

    // Check the current cycle, then drive inputs for the next rising edge
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d,
                                 input logic [N*WW-1:0] w);
        @(negedge clk);
        checkCycle();
        req    = r;
        done   = d;
        weight = w;
        modelStep(r, d, w);
    endtask

    task automatic doReset();
        @(negedge clk);
        checkCycle();
        #1 rstn = 1'b0;
        req  = '0;
        done = '0;
        #1;
        modelReset();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_vld", gnt_vld, 0);
        checkOutput("rst_id", gnt_id, 0);
        checkOutput("rst_timeout", timeout, 0);
        @(negedge clk);
        checkCycle();
        rstn     = 1'b1;
        prev_vld = 1'b0;
        seen_q.delete();
        to_count = 0;
    endtask

    task automatic checkOrder(input string tag, input int expd[8], input int cnt);
        checkOutput({tag, "_count"}, seen_q.size() >= cnt, 1);
        for (int i = 0; i < cnt; i++)
            checkOutput($sformatf("%s_%0d", tag, i), (i < seen_q.size()) ? seen_q[i] : 32'hdead, expd[i]);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        logic [N-1:0]    r, d;
        logic [N*WW-1:0] w;

        rstn   = 1'b0;
        req    = '0;
        done   = '0;
        weight = '0;
        modelReset();
        prev_vld = 1'b0;
        to_count = 0;

        // Equal weights, done on each grant's second cycle
        doReset();
        w = {4{3'd1}};
        repeat (16) begin
            d = (m_busy && m_age == 2) ? N'(1 << m_owner) : '0;
            applyStimulus(4'b1111, d, w);
        end
        checkOrder("order_equal", exp29, 5);

        // Requester 0 weighted 3, one-cycle holds
        doReset();
        w = {3'd1, 3'd1, 3'd1, 3'd3};
        repeat (20) begin
            d = (m_busy && m_age == 1) ? N'(1 << m_owner) : '0;
            applyStimulus(4'b0011, d, w);
        end
        checkOrder("order_weighted", exp30, 8);

        // Non-owner done is ignored; dropping req releases
        doReset();
        w = {4{3'd1}};
        applyStimulus(4'b0100, 4'b0000, w);
        applyStimulus(4'b0100, 4'b0000, w);
        applyStimulus(4'b0100, 4'b0010, w);
        applyStimulus(4'b0100, 4'b0000, w);
        checkOutput("foreign_done_hold", gnt, 4'b0100);
        applyStimulus(4'b0000, 4'b0000, w);
        applyStimulus(4'b0000, 4'b0000, w);
        checkOutput("req_drop_clear", gnt, 4'b0000);

        // Asynchronous reset while requester 3 owns the grant
        doReset();
        w = {3'd3, 3'd1, 3'd1, 3'd1};
        repeat (3) applyStimulus(4'b1000, 4'b0000, w);
        checkOutput("pre_reset_gnt", gnt, 4'b1000);
        doReset();
        repeat (2) applyStimulus(4'b1000, 4'b0000, w);
        checkOutput("post_reset_gnt", gnt, 4'b1000);
        checkOrder("order_reset", exp32, 1);

        // Owner never releases
        doReset();
        w = {4{3'd1}};
        applyStimulus(4'b0010, 4'b0000, w);
        repeat (14) applyStimulus(4'b0011, 4'b0000, w);
`ifdef WRR_TIMEOUT_EN
        checkOrder("order_timeout", exp33, 2);
        checkOutput("timeout_pulses", to_count, 1);
`else
        checkOrder("order_hold", exp33, 1);
        checkOutput("hold_no_timeout", to_count, 0);
        checkOutput("hold_gnt", gnt, 4'b0010);
`endif

        // Random traffic
        doReset();
        r = '0;
        w = {4{3'd1}};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 97 == 0) w = (N*WW)'($urandom);
            if (cyc == 1500) doReset();
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            d = (m_busy && $urandom_range(0, 2) == 0) ? N'(1 << m_owner) : '0;
            d = d | (N'($urandom) & N'($urandom));
            applyStimulus(r, d, w);
        end
        @(negedge clk);
        checkCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
